// File: rtl/gon_bus.sv
// Global output network bus: round-robin gather of source words onto one sink
// through a one-deep output register, each word tagged with its slot's
// scan-programmed tag.
//
// state   | meaning
// --------+-------------------------------------------------------------
// S_EMPTY | output register holds no word; sink_enable low
// S_FULL  | output register holds a word; value/tag stable until accepted
//
// The scan-shift enable is named program_en because "program" is a reserved
// word in SystemVerilog.
module gon_bus #(
   parameter int BITWIDTH    = 16,
   parameter int TAG_LENGTH  = 4,
   parameter int NUM_SOURCES = 10
) (
   input  logic                            clk,
   input  logic                            rstb,
   input  logic                            program_en,
   input  logic [TAG_LENGTH-1:0]           scan_tag_in,
   output logic [TAG_LENGTH-1:0]           scan_tag_out,
   input  logic [NUM_SOURCES-1:0]          source_enable,
   input  logic [BITWIDTH*NUM_SOURCES-1:0] source_data,
   output logic [NUM_SOURCES-1:0]          source_ready,
   output logic                            sink_enable,
   input  logic                            sink_ready,
   output logic [TAG_LENGTH-1:0]           sink_tag,
   output logic [BITWIDTH-1:0]             sink_value,
   output logic                            bus_busy
);

   localparam int PTR_W = (NUM_SOURCES > 1) ? $clog2(NUM_SOURCES) : 1;

   typedef enum logic {S_EMPTY, S_FULL} state_t;

   state_t                  state, state_nxt;
   logic [TAG_LENGTH-1:0]   tag_reg [NUM_SOURCES];
   logic [PTR_W-1:0]        rr_ptr;
   logic [PTR_W-1:0]        g_idx;
   logic [NUM_SOURCES-1:0]  g_oh;
   logic                    found;
   logic                    accept;
   logic                    grant;
   logic [BITWIDTH-1:0]     sel_value;
   logic [TAG_LENGTH-1:0]   sel_tag;

   assign accept       = !program_en && ((state == S_EMPTY) || sink_ready);
   assign grant        = accept && found;
   assign source_ready = grant ? g_oh : '0;
   assign sink_enable  = (state == S_FULL);
   assign bus_busy     = (state == S_FULL) || (|source_enable);
   assign scan_tag_out = tag_reg[NUM_SOURCES-1];

   // Round-robin pick: first requester at or above rr_ptr, else lowest requester (wrap).
   always_comb begin
      found = 1'b0;
      g_idx = '0;
      g_oh  = '0;
      for (int i = 0; i < NUM_SOURCES; i++) begin
         if (!found && source_enable[i] && (PTR_W'(i) >= rr_ptr)) begin
            found   = 1'b1;
            g_idx   = PTR_W'(i);
            g_oh[i] = 1'b1;
         end
      end
      for (int i = 0; i < NUM_SOURCES; i++) begin
         if (!found && source_enable[i]) begin
            found   = 1'b1;
            g_idx   = PTR_W'(i);
            g_oh[i] = 1'b1;
         end
      end
   end

   // Select the granted word and its slot tag (one-hot mux).
   always_comb begin
      sel_value = '0;
      sel_tag   = '0;
      for (int i = 0; i < NUM_SOURCES; i++) begin
         if (g_oh[i]) begin
            sel_value = source_data[BITWIDTH*i +: BITWIDTH];
            sel_tag   = tag_reg[i];
         end
      end
   end

   // Output register occupancy state.
   always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) state <= S_EMPTY;
      else       state <= state_nxt;
   end

   // Next-state: fill on grant, empty on drain without a refill.
   always_comb begin
      state_nxt = state;
      case (state)
         S_EMPTY: if (grant) state_nxt = S_FULL;
         S_FULL:  if (sink_ready && !grant) state_nxt = S_EMPTY;
         default: state_nxt = S_EMPTY;
      endcase
   end

   // Capture granted word/tag and advance the round-robin pointer past the winner.
   always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) begin
         sink_value <= '0;
         sink_tag   <= '0;
         rr_ptr     <= '0;
      end else if (grant) begin
         sink_value <= sel_value;
         sink_tag   <= sel_tag;
         rr_ptr     <= (g_idx == PTR_W'(NUM_SOURCES - 1)) ? '0 : g_idx + PTR_W'(1);
      end
   end

   // Tag scan chain: slot 0 takes scan input, each slot takes its predecessor.
   always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) begin
         for (int i = 0; i < NUM_SOURCES; i++) tag_reg[i] <= '0;
      end else if (program_en) begin
         tag_reg[0] <= scan_tag_in;
         for (int i = 1; i < NUM_SOURCES; i++) tag_reg[i] <= tag_reg[i-1];
      end
   end

endmodule

// File: tb/tb_gon_bus.sv
// Directed bench for gon_bus: expected sink words are queued as grants are
// issued and a negedge monitor pops and compares every accepted sink word.
module tb_gon_bus;

   localparam int B = 16;
   localparam int T = 4;
   localparam int N = 10;

   logic             clk = 1'b0;
   logic             rstb;
   logic             program_en;
   logic [T-1:0]     scan_tag_in;
   logic [T-1:0]     scan_tag_out;
   logic [N-1:0]     source_enable;
   logic [B*N-1:0]   source_data;
   logic [N-1:0]     source_ready;
   logic             sink_enable;
   logic             sink_ready;
   logic [T-1:0]     sink_tag;
   logic [B-1:0]     sink_value;
   logic             bus_busy;

   int checks = 0, errors = 0;
   int mon_checks = 0, mon_errors = 0;
   logic [T+B-1:0] exp_q [$];
   logic [T+B-1:0] mon_exp, mon_got;

   always #5 clk = ~clk;

   gon_bus #(.BITWIDTH(B), .TAG_LENGTH(T), .NUM_SOURCES(N)) dut (
      .clk           (clk),
      .rstb          (rstb),
      .program_en    (program_en),
      .scan_tag_in   (scan_tag_in),
      .scan_tag_out  (scan_tag_out),
      .source_enable (source_enable),
      .source_data   (source_data),
      .source_ready  (source_ready),
      .sink_enable   (sink_enable),
      .sink_ready    (sink_ready),
      .sink_tag      (sink_tag),
      .sink_value    (sink_value),
      .bus_busy      (bus_busy)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic src(input int i, input logic en, input logic [B-1:0] d);
      source_enable[i]       = en;
      source_data[B*i +: B]  = d;
   endtask

   task automatic expect_word(input logic [T-1:0] tag, input logic [B-1:0] val);
      exp_q.push_back({tag, val});
   endtask

   // Scoreboard monitor: every word the sink accepts must match the queue head.
   always @(negedge clk) begin
      if (rstb && sink_enable && sink_ready) begin
         mon_checks++;
         mon_got = {sink_tag, sink_value};
         if (exp_q.size() == 0) begin
            mon_errors++;
            $display("FAIL sink_word unexpected tag=%h value=%h", sink_tag, sink_value);
         end else begin
            mon_exp = exp_q.pop_front();
            if (mon_got !== mon_exp)
               begin
                  mon_errors++;
                  $display("FAIL sink_word actual tag=%h value=%h expected tag=%h value=%h",
                           mon_got[T+B-1:B], mon_got[B-1:0], mon_exp[T+B-1:B], mon_exp[B-1:0]);
               end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      rstb          = 1'b0;
      program_en    = 1'b0;
      scan_tag_in   = '0;
      source_enable = '0;
      source_data   = '0;
      sink_ready    = 1'b0;

      // Reset state
      @(negedge clk);
      chk("rst_sink_enable", 32'(sink_enable), 0);
      chk("rst_sink_value", 32'(sink_value), 0);
      chk("rst_sink_tag", 32'(sink_tag), 0);
      chk("rst_source_ready", 32'(source_ready), 0);
      chk("rst_scan_tag_out", 32'(scan_tag_out), 0);
      chk("rst_bus_busy", 32'(bus_busy), 0);
      tick();
      rstb = 1'b1;
      tick();

      // Program tags 0..9: slot i ends with tag 9-i
      program_en = 1'b1;
      for (int t = 0; t < N; t++) begin
         scan_tag_in = T'(t);
         tick();
      end
      program_en = 1'b0;
      scan_tag_in = '0;

      // Source 9 alone -> tag 0
      sink_ready = 1'b1;
      src(9, 1'b1, 16'h1234);
      @(negedge clk);
      chk("prog_scan_tag_out", 32'(scan_tag_out), 0);
      chk("s9_ready", 32'(source_ready), 32'h200);
      chk("s9_busy", 32'(bus_busy), 1);
      expect_word(4'd0, 16'h1234);
      tick();
      src(9, 1'b0, 16'h0);
      @(negedge clk);
      tick();

      // Round robin: all sources request, grants 0..9,0
      for (int i = 0; i < N; i++) src(i, 1'b1, 16'hA000 + 16'(i));
      for (int j = 0; j <= N; j++) begin
         @(negedge clk);
         chk("rr_ready", 32'(source_ready), 32'(1) << (j % N));
         chk("rr_sink_enable", 32'(sink_enable), (j == 0) ? 0 : 1);
         expect_word(T'(9 - (j % N)), 16'hA000 + 16'(j % N));
         tick();
      end
      source_enable = '0;
      @(negedge clk);
      tick();

      // Backpressure: fill with source 7, then hold sink_ready low
      sink_ready = 1'b0;
      src(7, 1'b1, 16'hA007);
      @(negedge clk);
      chk("bp_fill_ready", 32'(source_ready), 32'h080);
      expect_word(4'd2, 16'hA007);
      tick();
      src(7, 1'b0, 16'h0);
      src(2, 1'b1, 16'hA002);
      src(5, 1'b1, 16'hA005);
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         chk("bp_hold_ready", 32'(source_ready), 0);
         chk("bp_hold_value", 32'(sink_value), 32'hA007);
         tick();
      end
      sink_ready = 1'b1;
      @(negedge clk);
      chk("bp_release_ready", 32'(source_ready), 32'h004);
      expect_word(4'd7, 16'hA002);
      tick();
      src(2, 1'b0, 16'h0);
      @(negedge clk);
      chk("bp_next_ready", 32'(source_ready), 32'h020);
      expect_word(4'd4, 16'hA005);
      tick();
      src(5, 1'b0, 16'h0);
      @(negedge clk);
      tick();

      // Wrap: move rr_ptr to 8 via source 7, then sources 1 and 3
      src(7, 1'b1, 16'hB007);
      @(negedge clk);
      chk("wrap_pre_ready", 32'(source_ready), 32'h080);
      expect_word(4'd2, 16'hB007);
      tick();
      src(7, 1'b0, 16'h0);
      @(negedge clk);
      tick();
      src(1, 1'b1, 16'hA001);
      src(3, 1'b1, 16'hA003);
      @(negedge clk);
      chk("wrap_first_ready", 32'(source_ready), 32'h002);
      expect_word(4'd8, 16'hA001);
      tick();
      src(1, 1'b0, 16'h0);
      @(negedge clk);
      chk("wrap_second_ready", 32'(source_ready), 32'h008);
      expect_word(4'd6, 16'hA003);
      tick();
      src(3, 1'b0, 16'h0);
      @(negedge clk);
      tick();

      // Program blocking: 3 shifts (F,E,D) while source 4 requests; slot 4 tag becomes 8
      src(4, 1'b1, 16'hA004);
      program_en = 1'b1;
      for (int k = 0; k < 3; k++) begin
         scan_tag_in = T'(15 - k);
         @(negedge clk);
         chk("pgm_block_ready", 32'(source_ready), 0);
         tick();
      end
      program_en = 1'b0;
      @(negedge clk);
      chk("pgm_release_ready", 32'(source_ready), 32'h010);
      chk("pgm_scan_tag_out", 32'(scan_tag_out), 3);
      expect_word(4'd8, 16'hA004);
      tick();
      src(4, 1'b0, 16'h0);
      @(negedge clk);
      tick();

      // Reset while FULL: held word discarded, pointer and tags cleared
      sink_ready = 1'b0;
      src(6, 1'b1, 16'hA006);
      @(negedge clk);
      chk("rst_fill_ready", 32'(source_ready), 32'h040);
      tick();
      src(6, 1'b0, 16'h0);
      @(negedge clk);
      chk("rst_full_enable", 32'(sink_enable), 1);
      #1 rstb = 1'b0;
      #1;
      chk("rst_async_enable", 32'(sink_enable), 0);
      chk("rst_async_value", 32'(sink_value), 0);
      tick();
      rstb = 1'b1;
      sink_ready = 1'b1;
      src(0, 1'b1, 16'hC000);
      src(3, 1'b1, 16'hC003);
      @(negedge clk);
      chk("post_rst_ready", 32'(source_ready), 32'h001);
      expect_word(4'd0, 16'hC000);
      tick();
      src(0, 1'b0, 16'h0);
      @(negedge clk);
      chk("post_rst_next_ready", 32'(source_ready), 32'h008);
      expect_word(4'd0, 16'hC003);
      tick();
      src(3, 1'b0, 16'h0);
      @(negedge clk);
      tick();
      tick();

      chk("queue_drained", 32'(exp_q.size()), 0);
      checks += mon_checks;
      errors += mon_errors;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
